// File: rtl/alu_multicycle.sv
// Execute-stage ALU: RV32I integer ops in one cycle, plus MUL/MULHU/DIVU/REMU
// computed one bit per cycle behind a valid/ready handshake.
module alu_multicycle #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  LT,
  output logic                  LTU,
  output logic                  busy
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned CW  = $clog2(W) + 1;

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL   = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU  = 4'd9,  OP_MUL  = 4'd10, OP_MULHU = 4'd11,
    OP_DIVU = 4'd12, OP_REMU  = 4'd13, OP_RSV0 = 4'd14, OP_RSV1  = 4'd15
  } op_e;

  state_e         state_q, state_d;
  op_e            ctrl_q, ctrl_d;
  logic [W-1:0]   op1_q, op1_d;
  logic [W-1:0]   op2_q, op2_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   out_q, out_d;
  logic           eq_q, eq_d;
  logic           lt_q, lt_d;
  logic           ltu_q, ltu_d;
  logic           vld_q, vld_d;

  op_e            op_in;
  logic [W-1:0]   fa, fb;
  logic           eq_c, lt_c, ltu_c;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   single_res;
  logic           is_iter_in;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] step_next;
  logic [W-1:0]   iter_res;

  assign op_in = op_e'(ALUctrl);
  assign shamt = ALUop2[SHW-1:0];

  // Flags come from the operands of the op that is completing.
  assign fa    = (state_q == S_BUSY) ? op1_q : ALUop1;
  assign fb    = (state_q == S_BUSY) ? op2_q : ALUop2;
  assign eq_c  = (fa == fb);
  assign lt_c  = ($signed(fa) < $signed(fb));
  assign ltu_c = (fa < fb);

  assign is_iter_in = (op_in == OP_MUL) || (op_in == OP_MULHU) ||
                      (op_in == OP_DIVU) || (op_in == OP_REMU);

  always_comb begin
    single_res = '0;
    case (op_in)
      OP_ADD:  single_res = ALUop1 + ALUop2;
      OP_SUB:  single_res = ALUop1 - ALUop2;
      OP_AND:  single_res = ALUop1 & ALUop2;
      OP_OR:   single_res = ALUop1 | ALUop2;
      OP_XOR:  single_res = ALUop1 ^ ALUop2;
      OP_SLL:  single_res = ALUop1 << shamt;
      OP_SRL:  single_res = ALUop1 >> shamt;
      OP_SRA:  single_res = W'($signed(ALUop1) >>> shamt);
      OP_SLT:  single_res = W'(lt_c);
      OP_SLTU: single_res = W'(ltu_c);
      default: single_res = '0;
    endcase
  end

  // acc_q holds {product_hi, multiplier} for MUL and {remainder, quotient} for DIV;
  // both start as {0, op1}, so one register serves both algorithms.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, op2_q} : '0);
    div_shift = acc_q[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, op2_q};
    if ((ctrl_q == OP_MUL) || (ctrl_q == OP_MULHU)) begin
      step_next = {mul_sum, acc_q[W-1:1]};
    end else if (div_diff[W]) begin
      step_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      step_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
    case (ctrl_q)
      OP_MUL, OP_DIVU:   iter_res = step_next[W-1:0];
      OP_MULHU, OP_REMU: iter_res = step_next[2*W-1:W];
      default:           iter_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ctrl_d = op_in;
          op1_d  = ALUop1;
          op2_d  = ALUop2;
          if (is_iter_in) begin
            state_d = S_BUSY;
            cnt_d   = CW'(W);
            acc_d   = {{W{1'b0}}, ALUop1};
          end else begin
            out_d = single_res;
            eq_d  = eq_c;
            lt_d  = lt_c;
            ltu_d = ltu_c;
            vld_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          out_d   = iter_res;
          eq_d    = eq_c;
          lt_d    = lt_c;
          ltu_d   = ltu_c;
          vld_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= OP_ADD;
      op1_q   <= '0;
      op2_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = vld_q;
  assign ALUout    = out_q;
  assign EQ        = eq_q;
  assign LT        = lt_q;
  assign LTU       = ltu_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed checks of alu_multicycle against a plain-arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUctrl = '0;
  logic [31:0] ALUop1 = '0;
  logic [31:0] ALUop2 = '0;
  logic        out_valid;
  logic [31:0] ALUout;
  logic        EQ, LT, LTU, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_multicycle #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .out_valid(out_valid), .ALUout(ALUout), .EQ(EQ), .LT(LT), .LTU(LTU), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << (b % 32);
      4'd6:  return a >> (b % 32);
      4'd7:  return 32'($signed(a) >>> (b % 32));
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, $signed(a) < $signed(b), a < b};
  endfunction

  function automatic int unsigned ref_lat(input logic [3:0] c);
    return (c >= 4'd10 && c <= 4'd13) ? 33 : 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op, wait for its result, then check result, flags, latency and pulse width.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat;
    int unsigned guard;
    logic [31:0] exp_res;
    exp_res = ref_alu(c, a, b);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    ALUctrl = c; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ref_lat(c) > 1) begin
      chk({tag, "_busy"}, 64'({busy, in_ready}), 64'b10);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(c)));
    chk({tag, "_res"}, 64'(ALUout), 64'(exp_res));
    chk({tag, "_flags"}, 64'({EQ, LT, LTU}), 64'(ref_flags(a, b)));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'({out_valid, ALUout}), {31'd0, 1'b0, exp_res});
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    int unsigned npulse, first_k, add_k;
    logic [31:0] v1, v2;
    logic        acc_now;

    #12;
    chk("reset_outs", 64'({in_ready, out_valid, busy, EQ, LT, LTU, ALUout}),
        {29'd0, 3'b100, 3'b000, 32'd0});
    @(negedge clk);
    rst = 1'b1;

    run_op("add57",   4'd0,  32'd5, 32'd7);
    run_op("sub35",   4'd1,  32'd3, 32'd5);
    run_op("sra",     4'd7,  32'h8000_0000, 32'h24);
    run_op("ctrl15",  4'd15, 32'h1234, 32'h1234);
    run_op("mul",     4'd10, 32'hFFFF, 32'hFFFF);
    run_op("mulhu",   4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu",    4'd12, 32'd100, 32'd7);
    run_op("remu",    4'd13, 32'd100, 32'd7);
    run_op("divu0",   4'd12, 32'hDEAD_BEEF, 32'd0);
    run_op("remu0",   4'd13, 32'h1234, 32'd0);
    run_op("slt",     4'd8,  32'hFFFF_FFFF, 32'd1);
    run_op("sltu",    4'd9,  32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      run_op("rand", rc, ra, rb);
    end

    // Throughput: single-cycle ops with in_valid held produce one result per clock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ra = 32'($urandom); rb = 32'($urandom); rc = 4'($urandom_range(0, 9));
      ALUctrl = rc; ALUop1 = ra; ALUop2 = rb; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_res", 64'({out_valid, ALUout}), {31'd0, 1'b1, ref_alu(rc, ra, rb)});
    end
    @(negedge clk);
    in_valid = 1'b0;

    // MUL accepted, then ADD 1,2 held valid while busy: ADD accepted only once ready returns.
    @(negedge clk);
    ALUctrl = 4'd10; ALUop1 = 32'h0001_0003; ALUop2 = 32'h0000_0005; in_valid = 1'b1;
    @(posedge clk); #1;
    ALUctrl = 4'd0; ALUop1 = 32'd1; ALUop2 = 32'd2;
    npulse = 0; first_k = 0; add_k = 0; v1 = '0; v2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      acc_now = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc_now) begin
        in_valid = 1'b0;
        add_k = k;
      end
      if (out_valid) begin
        npulse++;
        if (npulse == 1) begin
          first_k = k; v1 = ALUout;
        end else begin
          v2 = ALUout;
        end
      end
    end
    chk("hold_pulses", 64'(npulse), 64'd2);
    chk("hold_mul_k", 64'(first_k), 64'd32);
    chk("hold_mul_v", 64'(v1), 64'(ref_alu(4'd10, 32'h0001_0003, 32'h0000_0005)));
    chk("hold_add_k", 64'(add_k), 64'd33);
    chk("hold_add_v", 64'(v2), 64'd3);

    // Reset 10 cycles into a DIVU aborts it.
    @(negedge clk);
    ALUctrl = 4'd12; ALUop1 = 32'd1000; ALUop2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_outs", 64'({in_ready, out_valid, busy, EQ, LT, LTU, ALUout}),
        {29'd0, 3'b100, 3'b000, 32'd0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) npulse++;
    end
    chk("arst_nopulse", 64'(npulse), 64'd0);
    run_op("post_rst_add", 4'd0, 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
